// File: rtl/key_expansion.sv
// Iterative AES key schedule: expands an NK-word key into all round-key words, one word per cycle.
// Define KEYEXP_SBOX_PIPE_EN to register the S-box output (words needing SubWord then take two cycles).
module key_expansion #(
  parameter int unsigned NK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NK*32-1:0]          key_in,
  output logic                      busy,
  output logic                      key_valid,
  output logic [4*(NK+7)*32-1:0]    key_out
);

  localparam int unsigned NR    = NK + 6;
  localparam int unsigned TOTAL = 4 * (NR + 1);
  localparam int unsigned IW    = $clog2(TOTAL);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("key_expansion: NK must be 4, 6 or 8");
  end

  // FIPS-197 forward S-box, entry 0x00 in the MSBs
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_SUB = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      ph_q, ph_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [31:0]     w_q [TOTAL];
`ifdef KEYEXP_SBOX_PIPE_EN
  logic [31:0]     sub_q, sub_d;
`endif

  logic            load_c, wr_c;
  logic [31:0]     word_c;
  logic [31:0]     prev_w, old_w, sub_in, t_sub;
  logic            rot_sel, need_sub, last_word;

  // ph_q tracks idx % NK so no divider is needed
  assign prev_w    = w_q[idx_q - IW'(1)];
  assign old_w     = w_q[idx_q - IW'(NK)];
  assign rot_sel   = (ph_q == 3'd0);
  assign need_sub  = rot_sel | ((NK == 8) && (ph_q == 3'd4));
  assign last_word = (idx_q == IW'(TOTAL - 1));
  assign sub_in    = rot_sel ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign t_sub     = sub_word(sub_in) ^ (rot_sel ? {rcon_q, 24'h0} : 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_EXPAND;
`ifdef KEYEXP_SBOX_PIPE_EN
      S_EXPAND: if (need_sub) state_d = S_SUB;
                else if (last_word) state_d = S_IDLE;
      S_SUB:    state_d = last_word ? S_IDLE : S_EXPAND;
`else
      S_EXPAND: if (last_word) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_c  = 1'b0;
    wr_c    = 1'b0;
    idx_d   = idx_q;
    ph_d    = ph_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    word_c  = old_w ^ (need_sub ? t_sub : prev_w);
`ifdef KEYEXP_SBOX_PIPE_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          idx_d   = IW'(NK);
          ph_d    = 3'd0;
          rcon_d  = 8'h01;
        end
      end
`ifdef KEYEXP_SBOX_PIPE_EN
      S_EXPAND: begin
        if (need_sub) sub_d = t_sub;
        else          wr_c  = 1'b1;
      end
      S_SUB: begin
        wr_c   = 1'b1;
        word_c = old_w ^ sub_q;
      end
`else
      S_EXPAND: wr_c = 1'b1;
`endif
      default: ;
    endcase
    if (wr_c) begin
      idx_d = idx_q + IW'(1);
      ph_d  = (ph_q == 3'(NK - 1)) ? 3'd0 : ph_q + 3'd1;
      if (rot_sel) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      if (last_word) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      ph_q    <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
      sub_q   <= '0;
`endif
      for (int i = 0; i < TOTAL; i++) w_q[i] <= '0;
    end else begin
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef KEYEXP_SBOX_PIPE_EN
      sub_q   <= sub_d;
`endif
      for (int i = 0; i < NK; i++) begin
        if (load_c) w_q[i] <= key_in[NK*32-1-32*i -: 32];
      end
      for (int i = NK; i < TOTAL; i++) begin
        if (wr_c && (idx_q == IW'(i))) w_q[i] <= word_c;
      end
    end
  end

  assign busy      = busy_q;
  assign key_valid = valid_q;

  for (genvar g = 0; g < TOTAL; g++) begin : g_pack
    assign key_out[TOTAL*32-1-32*g -: 32] = w_q[g];
  end

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: FIPS-197 vectors on NK=4/6/8, latency, hold, ignored start, mid-run reset.
module tb_key_expansion;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          st4, st6, st8;
  logic [127:0]  k4;
  logic [191:0]  k6;
  logic [255:0]  k8;
  logic          b4, b6, b8, v4, v6, v8;
  logic [1407:0] ko4;
  logic [1663:0] ko6;
  logic [1919:0] ko8;

  int n_cmp = 0;
  int n_bad = 0;
  int l4, l6, l8;

`ifdef KEYEXP_SBOX_PIPE_EN
  localparam int LAT4 = 50, LAT6 = 54, LAT8 = 65;
`else
  localparam int LAT4 = 40, LAT6 = 46, LAT8 = 52;
`endif

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;
  localparam logic [191:0] K3 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K4 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expansion #(.NK(4)) u4 (.clk(clk), .rst(rst), .start(st4), .key_in(k4),
                              .busy(b4), .key_valid(v4), .key_out(ko4));
  key_expansion #(.NK(6)) u6 (.clk(clk), .rst(rst), .start(st6), .key_in(k6),
                              .busy(b6), .key_valid(v6), .key_out(ko6));
  key_expansion #(.NK(8)) u8 (.clk(clk), .rst(rst), .start(st8), .key_in(k8),
                              .busy(b8), .key_valid(v8), .key_out(ko8));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd4(input int i);
    return ko4[1407-32*i -: 32];
  endfunction
  function automatic logic [31:0] wd6(input int i);
    return ko6[1663-32*i -: 32];
  endfunction
  function automatic logic [31:0] wd8(input int i);
    return ko8[1919-32*i -: 32];
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the start edge
  task automatic kick(input logic [2:0] mask);
    st4 = mask[0];
    st6 = mask[1];
    st8 = mask[2];
    @(posedge clk);
    #1;
    st4 = 1'b0;
    st6 = 1'b0;
    st8 = 1'b0;
  endtask

  // Counts edges after the start edge until key_valid; -1 if the bound expires
  task automatic wait_done(input logic [2:0] mask, input int pulse_at,
                           output int o4, output int o6, output int o8);
    int n;
    n  = 0;
    o4 = -1;
    o6 = -1;
    o8 = -1;
    while (n < 100 && ((mask[0] && o4 < 0) || (mask[1] && o6 < 0) || (mask[2] && o8 < 0))) begin
      st4 = (n == pulse_at);
      @(posedge clk);
      n++;
      #1;
      if (mask[0] && o4 < 0 && v4) o4 = n;
      if (mask[1] && o6 < 0 && v6) o6 = n;
      if (mask[2] && o8 < 0 && v8) o8 = n;
    end
    st4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
    k4 = '0; k6 = '0; k8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy4", 32'(b4), 32'd0);
    check_eq("rst_valid4", 32'(v4), 32'd0);
    check_eq("rst_keyout4", 32'(|ko4), 32'd0);
    check_eq("rst_valid8", 32'(v8), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vectors 1, 3, 4 in parallel; keys scrambled right after the start edge
    k4 = K1; k6 = K3; k8 = K4;
    kick(3'b111);
    check_eq("start_busy4", 32'(b4), 32'd1);
    check_eq("start_valid4", 32'(v4), 32'd0);
    k4 = ~K1; k6 = '0; k8 = {8{32'hdeadbeef}};
    wait_done(3'b111, -1, l4, l6, l8);
    check_eq("lat_nk4", 32'(l4), 32'(LAT4));
    check_eq("lat_nk6", 32'(l6), 32'(LAT6));
    check_eq("lat_nk8", 32'(l8), 32'(LAT8));
    check_eq("nk4_w4", wd4(4), 32'ha0fafe17);
    check_eq("nk4_w43", wd4(43), 32'hb6630ca6);
    check_eq("nk4_w0", wd4(0), 32'h2b7e1516);
    check_eq("nk6_w6", wd6(6), 32'hfe0c91f7);
    check_eq("nk6_w51", wd6(51), 32'h01002202);
    check_eq("nk8_w8", wd8(8), 32'h9ba35411);
    check_eq("nk8_w59", wd8(59), 32'h706c631e);
    check_eq("done_busy8", 32'(b8), 32'd0);

    // Result holds after completion
    repeat (5) @(posedge clk);
    #1;
    check_eq("hold_valid4", 32'(v4), 32'd1);
    check_eq("hold_busy4", 32'(b4), 32'd0);
    check_eq("hold_w43", wd4(43), 32'hb6630ca6);

    // Re-expansion from valid with vector 2
    k4 = K2;
    kick(3'b001);
    check_eq("reexp_valid_drop", 32'(v4), 32'd0);
    check_eq("reexp_busy", 32'(b4), 32'd1);
    wait_done(3'b001, -1, l4, l6, l8);
    check_eq("lat_v2", 32'(l4), 32'(LAT4));
    check_eq("v2_w4", wd4(4), 32'he232fcf1);
    check_eq("v2_w43", wd4(43), 32'h3b316f26);

    // Start pulsed mid-run with a different key is ignored
    k4 = K1;
    kick(3'b001);
    k4 = K2;
    wait_done(3'b001, 10, l4, l6, l8);
    check_eq("ign_lat", 32'(l4), 32'(LAT4));
    check_eq("ign_w4", wd4(4), 32'ha0fafe17);
    check_eq("ign_w43", wd4(43), 32'hb6630ca6);

    // Asynchronous reset mid-expansion, then a fresh full run
    kick(3'b001);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort_busy4", 32'(b4), 32'd0);
    check_eq("abort_valid4", 32'(v4), 32'd0);
    check_eq("abort_keyout4", 32'(|ko4), 32'd0);
    check_eq("abort_valid6", 32'(v6), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    k4 = K1;
    kick(3'b001);
    wait_done(3'b001, -1, l4, l6, l8);
    check_eq("post_rst_lat", 32'(l4), 32'(LAT4));
    check_eq("post_rst_w4", wd4(4), 32'ha0fafe17);
    check_eq("post_rst_w43", wd4(43), 32'hb6630ca6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
